// File: rtl/demux_serializer.sv
// Serializer feeding a 1:8 serial demux: takes (channel, word) pairs over valid/ready
// and shifts each word out MSB-first while holding the channel select for the frame.
module demux_serializer #(
  parameter int DATA_W   = 8,
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic [2:0]        sel,
  output logic              ser_out,
  output logic              busy,
  output logic              frame_start,
  output logic              frame_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_sel;
  logic              r_ser;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_gap;
  logic              r_fs;
  logic              r_fd;
  logic              w_xfer;

  // Ready drops during reset so no word can be accepted while the block is held.
  assign in_ready    = (r_state == IDLE) && rst_n;
  assign busy        = !in_ready;
  assign w_xfer      = in_valid && in_ready;
  assign sel         = r_sel;
  assign ser_out     = r_ser;
  assign frame_start = r_fs;
  assign frame_done  = r_fd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ser   <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_fs    <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      r_fd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_sel   <= in_ch;
            r_ser   <= in_data[DATA_W-1];
            r_shift <= in_data << 1;
            r_cnt   <= CNT_W'(DATA_W - 1);
            r_fs    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_ser   <= r_shift[DATA_W-1];
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt - CNT_W'(1);
          end else begin
            // One forced zero cycle on ser_out separates frames even with no gap.
            r_ser   <= 1'b0;
            r_fd    <= 1'b1;
            r_gap   <= 8'(IDLE_GAP);
            r_state <= (IDLE_GAP > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          r_gap <= r_gap - 8'd1;
          if (r_gap <= 8'd1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_serializer.sv
// Directed bench for demux_serializer: one instance with a one-cycle gap and one with
// no gap, driven on falling edges and checked against hand-computed bit sequences.
module tb_demux_serializer;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a_valid, a_ready, a_ser, a_busy, a_fs, a_fd;
  logic [2:0] a_ch, a_sel;
  logic [7:0] a_data;

  logic       b_valid, b_ready, b_ser, b_busy, b_fs, b_fd;
  logic [2:0] b_ch, b_sel;
  logic [7:0] b_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] words [4] = '{8'h81, 8'h7E, 8'hC3, 8'h5A};

  always #5 clk = ~clk;

  demux_serializer #(.DATA_W(8), .IDLE_GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_ch(a_ch), .in_data(a_data), .sel(a_sel), .ser_out(a_ser),
    .busy(a_busy), .frame_start(a_fs), .frame_done(a_fd)
  );

  demux_serializer #(.DATA_W(8), .IDLE_GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_ch(b_ch), .in_data(b_data), .sel(b_sel), .ser_out(b_ser),
    .busy(b_busy), .frame_start(b_fs), .frame_done(b_fd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the falling edge of cycle T with the word already presented.
  // Corrupts and drops the inputs mid-frame, then presents (hold, nch, nd) in T+9.
  task automatic frame_a(input logic [2:0] ch, input logic [7:0] d,
                         input logic hold, input logic [2:0] nch, input logic [7:0] nd);
    #1;
    chk("a_ready_at_T", 32'(a_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("a_sel_bit%0d", k), 32'(a_sel), 32'(ch));
      chk($sformatf("a_ser_bit%0d", k), 32'(a_ser), 32'(d[7-k]));
      chk($sformatf("a_fs_bit%0d", k), 32'(a_fs), 32'(k == 0));
      chk($sformatf("a_fd_bit%0d", k), 32'(a_fd), 32'd0);
      chk($sformatf("a_ready_bit%0d", k), 32'(a_ready), 32'd0);
      if (k == 0) begin
        a_valid = 1'b1;
        a_ch    = ~ch;
        a_data  = ~d;
      end
      if (k == 4) a_valid = 1'b0;
    end
    @(negedge clk);
    chk("a_ser_done", 32'(a_ser), 32'd0);
    chk("a_fd_done", 32'(a_fd), 32'd1);
    chk("a_fs_done", 32'(a_fs), 32'd0);
    chk("a_busy_gap", 32'(a_busy), 32'd1);
    chk("a_sel_gap", 32'(a_sel), 32'(ch));
    a_valid = hold;
    a_ch    = nch;
    a_data  = nd;
    @(negedge clk);
    #1;
    chk("a_ready_back", 32'(a_ready), 32'd1);
    chk("a_fd_clear", 32'(a_fd), 32'd0);
    chk("a_ser_idle", 32'(a_ser), 32'd0);
    chk("a_sel_hold", 32'(a_sel), 32'(ch));
  endtask

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b1; a_ch = 3'd3; a_data = 8'hFF;
    b_valid = 1'b1; b_ch = 3'd3; b_data = 8'hFF;

    // Reset held for three cycles with a valid word presented
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_ready_c%0d", c), 32'(a_ready), 32'd0);
      chk($sformatf("rst_sel_c%0d", c), 32'(a_sel), 32'd0);
      chk($sformatf("rst_ser_c%0d", c), 32'(a_ser), 32'd0);
      chk($sformatf("rst_fs_c%0d", c), 32'(a_fs), 32'd0);
      chk($sformatf("rst_fd_c%0d", c), 32'(a_fd), 32'd0);
      chk($sformatf("rst_b_ready_c%0d", c), 32'(b_ready), 32'd0);
    end
    rst_n   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1;
    chk("post_rst_ready", 32'(a_ready), 32'd1);
    chk("post_rst_busy", 32'(a_busy), 32'd0);
    @(negedge clk);
    chk("post_rst_fs", 32'(a_fs), 32'd0);
    chk("post_rst_ser", 32'(a_ser), 32'd0);
    chk("post_rst_sel", 32'(a_sel), 32'd0);

    // Single frame
    a_valid = 1'b1; a_ch = 3'd5; a_data = 8'hA5;
    frame_a(3'd5, 8'hA5, 1'b0, 3'd0, 8'h00);

    // Back-to-back with valid held
    a_valid = 1'b1; a_ch = 3'd2; a_data = 8'h81;
    frame_a(3'd2, 8'h81, 1'b1, 3'd6, 8'h3C);
    frame_a(3'd6, 8'h3C, 1'b0, 3'd0, 8'h00);

    // Boundary channels and data
    a_valid = 1'b1; a_ch = 3'd7; a_data = 8'hFF;
    frame_a(3'd7, 8'hFF, 1'b1, 3'd0, 8'h00);
    frame_a(3'd0, 8'h00, 1'b0, 3'd0, 8'h00);

    // Reset after four bits of 0xF0
    a_valid = 1'b1; a_ch = 3'd4; a_data = 8'hF0;
    #1;
    chk("mid_ready_T", 32'(a_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mid_ser_bit%0d", k), 32'(a_ser), 32'd1);
      chk($sformatf("mid_sel_bit%0d", k), 32'(a_sel), 32'd4);
      if (k == 0) a_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ser", 32'(a_ser), 32'd0);
    chk("mid_rst_sel", 32'(a_sel), 32'd0);
    chk("mid_rst_fd", 32'(a_fd), 32'd0);
    chk("mid_rst_fs", 32'(a_fs), 32'd0);
    chk("mid_rst_ready", 32'(a_ready), 32'd0);
    rst_n   = 1'b1;
    a_valid = 1'b1; a_ch = 3'd1; a_data = 8'h96;
    frame_a(3'd1, 8'h96, 1'b0, 3'd0, 8'h00);

    // Streaming with no gap: period must be exactly 9 cycles
    b_valid = 1'b1; b_ch = 3'd1; b_data = words[0];
    #1;
    chk("b_ready_first", 32'(b_ready), 32'd1);
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk($sformatf("b_w%0d_sel_bit%0d", w, k), 32'(b_sel), 32'(w + 1));
        chk($sformatf("b_w%0d_ser_bit%0d", w, k), 32'(b_ser), 32'(words[w][7-k]));
        chk($sformatf("b_w%0d_fs_bit%0d", w, k), 32'(b_fs), 32'(k == 0));
        chk($sformatf("b_w%0d_ready_bit%0d", w, k), 32'(b_ready), 32'd0);
        if (k == 0) begin
          if (w < 3) begin
            b_ch   = 3'(w + 2);
            b_data = words[w+1];
          end else begin
            b_valid = 1'b0;
          end
        end
      end
      @(negedge clk);
      chk($sformatf("b_w%0d_ser_sep", w), 32'(b_ser), 32'd0);
      chk($sformatf("b_w%0d_fd", w), 32'(b_fd), 32'd1);
      chk($sformatf("b_w%0d_ready_sep", w), 32'(b_ready), 32'd1);
      chk($sformatf("b_w%0d_sel_sep", w), 32'(b_sel), 32'(w + 1));
    end
    @(negedge clk);
    chk("b_end_fs", 32'(b_fs), 32'd0);
    chk("b_end_ser", 32'(b_ser), 32'd0);
    chk("b_end_busy", 32'(b_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
